// File: rtl/pmu_i2c_slave_pkg.sv
// Shared definitions for the PMU-emulating I2C target and the master-side block.
package pmu_i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic [7:0] PMU_I2C_WR = 8'h68;
    localparam logic [7:0] PMU_I2C_RD = 8'h69;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pmu_i2c_slave_i2c_bus_cond.sv
// Pad synchronisers for SCL/SDA plus one-cycle START, STOP and SCL edge pulses.
module i2c_bus_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;

endmodule

// File: rtl/pmu_i2c_slave.sv
// I2C target emulating the PMU register file: subaddress writes, repeated-start reads.
module pmu_i2c_slave
    import pmu_i2c_slave_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h34,
    parameter int unsigned REG_AW      = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              reg_wr_en,
    output logic [REG_AW-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data,
    input  logic [REG_AW-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              busy,
    output logic [7:0]        nak_count
);

    localparam int unsigned DEPTH = 1 << REG_AW;

    logic sda_s, start_p, stop_p, scl_rise, scl_fall;

    i2c_bus_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_cond (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_in),
        .sda_i     (sda_in),
        .sda_o     (sda_s),
        .start_o   (start_p),
        .stop_o    (stop_p),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall)
    );

    i2c_state_e        state_q, state_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [6:0]        shift_in_q, shift_in_d;
    logic [7:0]        shift_out_q, shift_out_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              busy_q, busy_d;
    logic              sda_oe_q, sda_oe_d;
    logic [7:0]        nak_q, nak_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        regs_q [DEPTH];
    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;

    assign rx_byte = {shift_in_q, sda_s};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        sda_oe_d    = sda_oe_q;
        nak_d       = nak_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (stop_p) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_p) begin
            state_d  = ADDR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                // Byte decisions are taken on the 8th rising edge; bitcnt==8 then
                // marks "waiting for the falling edge that opens the ack slot".
                ADDR, SUB, WR: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shift_in_d = rx_byte[6:0];
                        bitcnt_d   = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    busy_d = 1'b1;
                                    rw_d   = rx_byte[0];
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == SUB) begin
                                if (32'(rx_byte) < DEPTH) begin
                                    ptr_d = rx_byte[REG_AW-1:0];
                                end else begin
                                    nak_d   = sat_inc8(nak_q);
                                    state_d = IGNORE;
                                end
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = rx_byte;
                                ptr_d     = ptr_q + REG_AW'(1);
                            end
                        end
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = (state_q == ADDR) ? ADDR_ACK :
                                   (state_q == SUB)  ? SUB_ACK  : WR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d     = RD;
                            sda_oe_d    = ~rd_byte[7];
                            shift_out_d = {rd_byte[6:0], 1'b0};
                            bitcnt_d    = 4'd1;
                        end else begin
                            state_d  = SUB;
                            sda_oe_d = 1'b0;
                            bitcnt_d = '0;
                        end
                    end
                end
                SUB_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        state_d  = WR;
                        sda_oe_d = 1'b0;
                        bitcnt_d = '0;
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (bitcnt_q < 4'd8) begin
                            sda_oe_d    = ~shift_out_q[7];
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                            bitcnt_d    = bitcnt_q + 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d = ptr_q + REG_AW'(1);
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall) begin
                        state_d     = RD;
                        sda_oe_d    = ~rd_byte[7];
                        shift_out_d = {rd_byte[6:0], 1'b0};
                        bitcnt_d    = 4'd1;
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            nak_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            regs_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            sda_oe_q    <= sda_oe_d;
            nak_q       <= nak_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            if (wr_en_d) begin
                regs_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign sda_oe      = sda_oe_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign host_rdata  = regs_q[host_addr];
    assign busy        = busy_q;
    assign nak_count   = nak_q;

endmodule

// File: tb/tb_pmu_i2c_slave.sv
// Randomised bus-level bench for pmu_i2c_slave against a transaction-level register model.
module tb_pmu_i2c_slave;

    localparam int T = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       reg_wr_en;
    logic [5:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [5:0] host_addr = '0;
    logic [7:0] host_rdata;
    logic       busy;
    logic [7:0] nak_count;

    assign sda_bus = sda_m & ~sda_oe;

    pmu_i2c_slave #(
        .DEV_ADDR   (7'h34),
        .REG_AW     (6),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .busy       (busy),
        .nak_count  (nak_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem [64];
    int unsigned mptr = 0;
    int unsigned mnak = 0;
    logic [13:0] exp_wr[$];
    logic [13:0] got_wr[$];
    int          wr_idx = 0;
    int          oe_cycles = 0;
    logic [7:0]  wdata[$];
    logic [7:0]  last_rd;

    always @(negedge clk) begin
        if (reg_wr_en) got_wr.push_back({reg_wr_addr, reg_wr_data});
        if (sda_oe) oe_cycles = oe_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        s = sda_bus;
        wait_clk(T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        sda_m = 1'b0;
        wait_clk(T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        sda_m = 1'b1;
        wait_clk(2 * T);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, s);
            d = {d[6:0], s};
        end
        bit_cycle(~mack, s);
    endtask

    task automatic check_wr_log(input string tag);
        check({tag, "_wr_count"}, got_wr.size() - wr_idx, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && wr_idx + i < got_wr.size(); i++)
            check({tag, "_wr_pulse"}, got_wr[wr_idx + i], exp_wr[i]);
        wr_idx = got_wr.size();
        exp_wr.delete();
    endtask

    task automatic peek(input logic [5:0] a);
        @(negedge clk);
        host_addr = a;
        #1;
        check("peek", host_rdata, mem[a]);
    endtask

    // Model: a valid subaddress sets the pointer, each data byte lands at the
    // pointer which then wraps modulo 64; an invalid one NAKs and changes nothing.
    task automatic do_write(input logic [7:0] sub);
        logic ack;
        logic valid;
        valid = (sub < 8'd64);
        i2c_start();
        wr_byte(8'h68, ack);
        check("w_addr_ack", ack, 1'b1);
        check("w_busy", busy, 1'b1);
        wr_byte(sub, ack);
        check("w_sub_ack", ack, valid);
        if (valid) mptr = sub;
        else if (mnak < 255) mnak++;
        foreach (wdata[i]) begin
            wr_byte(wdata[i], ack);
            check("w_data_ack", ack, valid);
            if (valid) begin
                mem[mptr] = wdata[i];
                exp_wr.push_back({mptr[5:0], wdata[i]});
                mptr = (mptr + 1) % 64;
            end
        end
        i2c_stop();
        check("w_busy_after_p", busy, 1'b0);
        check("w_nak_count", nak_count, mnak);
        check_wr_log("w");
    endtask

    task automatic do_read(input logic set_sub, input logic [7:0] sub, input int n);
        logic ack;
        i2c_start();
        if (set_sub) begin
            wr_byte(8'h68, ack);
            check("r_waddr_ack", ack, 1'b1);
            wr_byte(sub, ack);
            check("r_sub_ack", ack, 1'b1);
            mptr = sub;
            i2c_start();
        end
        wr_byte(8'h69, ack);
        check("r_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i < n - 1, last_rd);
            check("r_data", last_rd, mem[mptr]);
            if (i < n - 1) mptr = (mptr + 1) % 64;
        end
        check("r_released", sda_oe, 1'b0);
        i2c_stop();
        check("r_busy_after_p", busy, 1'b0);
        check_wr_log("r");
    endtask

    task automatic do_badaddr(input logic [7:0] a, input logic [7:0] b);
        logic ack;
        int   oe0;
        oe0 = oe_cycles;
        i2c_start();
        wr_byte(a, ack);
        check("bad_addr_ack", ack, 1'b0);
        wr_byte(b, ack);
        check("bad_next_ack", ack, 1'b0);
        i2c_stop();
        check("bad_oe_cycles", oe_cycles - oe0, 0);
        check("bad_nak_count", nak_count, mnak);
        check_wr_log("bad");
    endtask

    initial begin
        logic       ack;
        logic [7:0] a;
        int         kind;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(5);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_nak", nak_count, 8'd0);
        check("rst_wr_en", reg_wr_en, 1'b0);
        peek(6'h2A);

        wdata = '{8'h9B};
        do_write(8'h10);
        peek(6'h10);
        check("dir_0x10", host_rdata, 8'h9B);

        wdata = '{8'h15};
        do_write(8'h32);
        do_read(1'b1, 8'h32, 1);
        check("dir_rd_0x32", last_rd, 8'h15);

        do_badaddr(8'h6A, 8'h10);
        check("dir_bad_nak0", nak_count, 8'd0);

        wdata = '{8'hAA};
        do_write(8'h40);
        check("dir_badsub_nak1", nak_count, 8'd1);

        wdata = '{8'h11, 8'h22};
        do_write(8'h3F);
        peek(6'h3F);
        check("dir_wrap_3f", host_rdata, 8'h11);
        peek(6'h00);
        check("dir_wrap_00", host_rdata, 8'h22);

        for (int t = 0; t < 25; t++) begin
            kind = $urandom_range(0, 4);
            if (kind <= 1) begin
                wdata.delete();
                repeat ($urandom_range(1, 3)) wdata.push_back(8'($urandom));
                do_write(8'($urandom_range(0, 79)));
            end else if (kind == 2) begin
                do_read(1'b1, 8'($urandom_range(0, 63)), $urandom_range(1, 3));
            end else if (kind == 3) begin
                do_read(1'b0, 8'h00, $urandom_range(1, 3));
            end else begin
                a = 8'($urandom);
                while (a[7:1] == 7'h34) a = 8'($urandom);
                do_badaddr(a, 8'($urandom));
            end
            peek(6'($urandom_range(0, 63)));
        end

        // Aborted write: STOP after four data bits must not write anything.
        i2c_start();
        wr_byte(8'h68, ack);
        wr_byte(8'h20, ack);
        for (int i = 0; i < 4; i++) bit_cycle(1'b0, ack);
        i2c_stop();
        check_wr_log("abort");
        peek(6'h20);

        wdata = '{8'h15};
        do_write(8'h05);
        i2c_start();
        wr_byte(8'h68, ack);
        wr_byte(8'h05, ack);
        i2c_start();
        wr_byte(8'h69, ack);
        check("rst_mid_driving", sda_oe, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_oe", sda_oe, 1'b0);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mptr = 0;
        mnak = 0;
        wait_clk(4);
        check("rst2_busy", busy, 1'b0);
        check("rst2_nak", nak_count, 8'd0);
        for (int i = 0; i < 64; i++) peek(6'(i));
        check_wr_log("rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
